mem_access: RTL and testbench

Memory-access stage of the pipeline, sitting directly downstream of the execute stage. It consumes the registered opcode and ALU result, performs word loads and stores on the data-memory port with a req/gnt/rvalid handshake, and produces one registered writeback record per completed instruction. It back-pressures execute while a memory transaction is outstanding.

---
 rtl/mem_access.sv | 135 +++++++++++++
 tb/tb_mem_access.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : Pipeline memory-access stage. Performs word loads and stores
//               over a req/gnt/rvalid port and emits one registered
//               writeback record per completed instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access #(
    parameter int TIMEOUT = 255
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        in_valid_i,
    output logic             in_ready_o,
    input  wire logic [4:0]  opcode_i,
    input  wire logic [31:0] alu_result_i,
    input  wire logic [31:0] store_data_i,
    input  wire logic [4:0]  rd_addr_i,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic [31:0]      dmem_addr_o,
    output logic [31:0]      dmem_wdata_o,
    input  wire logic        dmem_gnt_i,
    input  wire logic        dmem_rvalid_i,
    input  wire logic [31:0] dmem_rdata_i,
    output logic             wb_valid_o,
    output logic [4:0]       wb_rd_o,
    output logic [31:0]      wb_data_o,
    output logic             misalign_o,
    output logic             bus_err_o
);

    localparam logic [4:0] c_OP_LW  = 5'b00001;
    localparam logic [4:0] c_OP_SW  = 5'b00010;
    localparam logic [4:0] c_OP_NOP = 5'b11111;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_REQ  = 2'd1;
    localparam logic [1:0] c_S_WAIT = 2'd2;

    // Last counter value before the timeout fires; the abort lands TIMEOUT
    // cycles after entering WAIT.
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0] r_state;
    logic [7:0] r_cnt;
    logic [4:0] r_rd;

    logic w_is_lw;
    logic w_is_sw;
    logic w_is_mem;

    assign w_is_lw    = (opcode_i == c_OP_LW);
    assign w_is_sw    = (opcode_i == c_OP_SW);
    assign w_is_mem   = w_is_lw | w_is_sw;
    assign in_ready_o = (r_state == c_S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_S_IDLE;
            r_cnt        <= '0;
            r_rd         <= '0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            wb_valid_o   <= 1'b0;
            wb_rd_o      <= '0;
            wb_data_o    <= '0;
            misalign_o   <= 1'b0;
            bus_err_o    <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;

            case (r_state)
                c_S_IDLE: begin
                    if (in_valid_i) begin
                        r_rd <= rd_addr_i;
                        if (w_is_mem) begin
                            if (alu_result_i[1:0] != 2'b00) begin
                                misalign_o <= 1'b1;
                            end else begin
                                r_state      <= c_S_REQ;
                                dmem_req_o   <= 1'b1;
                                dmem_we_o    <= w_is_sw;
                                dmem_addr_o  <= alu_result_i;
                                dmem_wdata_o <= w_is_sw ? store_data_i : '0;
                            end
                        end else if (opcode_i != c_OP_NOP) begin
                            wb_valid_o <= (rd_addr_i != 5'd0);
                            wb_rd_o    <= rd_addr_i;
                            wb_data_o  <= alu_result_i;
                        end
                    end
                end

                c_S_REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_o   <= 1'b0;
                        dmem_we_o    <= 1'b0;
                        dmem_addr_o  <= '0;
                        dmem_wdata_o <= '0;
                        if (dmem_we_o) begin
                            r_state <= c_S_IDLE;
                        end else begin
                            r_state <= c_S_WAIT;
                            r_cnt   <= '0;
                        end
                    end
                end

                c_S_WAIT: begin
                    if (dmem_rvalid_i) begin
                        wb_valid_o <= (r_rd != 5'd0);
                        wb_rd_o    <= r_rd;
                        wb_data_o  <= dmem_rdata_i;
                        r_state    <= c_S_IDLE;
                    end else if (r_cnt == c_TO_LAST) begin
                        bus_err_o <= 1'b1;
                        r_state   <= c_S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                default: r_state <= c_S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Directed, table-driven bench for mem_access (TIMEOUT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    logic        clk;
    logic        rst_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [4:0]  opcode_i;
    logic [31:0] alu_result_i;
    logic [31:0] store_data_i;
    logic [4:0]  rd_addr_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        misalign_o;
    logic        bus_err_o;

    int n_cmp = 0;
    int n_err = 0;

    mem_access #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .opcode_i     (opcode_i),
        .alu_result_i (alu_result_i),
        .store_data_i (store_data_i),
        .rd_addr_i    (rd_addr_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_gnt_i   (dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i (dmem_rdata_i),
        .wb_valid_o   (wb_valid_o),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o),
        .misalign_o   (misalign_o),
        .bus_err_o    (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [4:0]  op;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        e_wb;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_mis;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid_i   = 1'b0;
        opcode_i     = 5'b11111;
        alu_result_i = '0;
        store_data_i = '0;
        rd_addr_i    = '0;
    endtask

    task automatic accept(input logic [4:0] op, input logic [31:0] alu,
                          input logic [31:0] sdata, input logic [4:0] rd);
        in_valid_i   = 1'b1;
        opcode_i     = op;
        alu_result_i = alu;
        store_data_i = sdata;
        rd_addr_i    = rd;
        step();
        // Garbage after acceptance must not disturb the transaction.
        in_valid_i   = 1'b0;
        opcode_i     = 5'b00000;
        alu_result_i = 32'hFFFF_FFF0;
        store_data_i = 32'hFFFF_FFFF;
        rd_addr_i    = 5'd30;
    endtask

    initial begin
        drive_idle();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        rst_n         = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst ready",    32'(in_ready_o), 32'd1);
        chk("rst req",      32'(dmem_req_o), 32'd0);
        chk("rst we",       32'(dmem_we_o),  32'd0);
        chk("rst addr",     dmem_addr_o,     32'd0);
        chk("rst wdata",    dmem_wdata_o,    32'd0);
        chk("rst wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst wb_rd",    32'(wb_rd_o),    32'd0);
        chk("rst wb_data",  wb_data_o,       32'd0);
        chk("rst misalign", 32'(misalign_o), 32'd0);
        chk("rst bus_err",  32'(bus_err_o),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single-cycle instructions: ALU, NOP, rd=0, misaligned, no-valid.
        vecs[0] = '{1'b1, 5'b00000, 32'h0000_0005, 5'd3,  1'b1, 5'd3,  32'h0000_0005, 1'b0};
        vecs[1] = '{1'b1, 5'b00000, 32'h0000_0005, 5'd3,  1'b1, 5'd3,  32'h0000_0005, 1'b0};
        vecs[2] = '{1'b1, 5'b00000, 32'h0000_0005, 5'd3,  1'b1, 5'd3,  32'h0000_0005, 1'b0};
        vecs[3] = '{1'b1, 5'b00000, 32'h0000_0005, 5'd3,  1'b1, 5'd3,  32'h0000_0005, 1'b0};
        vecs[4] = '{1'b1, 5'b11111, 32'h0000_0009, 5'd4,  1'b0, 5'd0,  32'h0,         1'b0};
        vecs[5] = '{1'b1, 5'b01010, 32'h0000_CAFE, 5'd0,  1'b0, 5'd0,  32'h0,         1'b0};
        vecs[6] = '{1'b1, 5'b00001, 32'h0000_0102, 5'd5,  1'b0, 5'd0,  32'h0,         1'b1};
        vecs[7] = '{1'b1, 5'b00010, 32'h0000_0041, 5'd6,  1'b0, 5'd0,  32'h0,         1'b1};
        vecs[8] = '{1'b1, 5'b10000, 32'h1234_0000, 5'd31, 1'b1, 5'd31, 32'h1234_0000, 1'b0};
        vecs[9] = '{1'b0, 5'b00000, 32'h0000_0077, 5'd3,  1'b0, 5'd0,  32'h0,         1'b0};

        for (int i = 0; i < 10; i++) begin
            in_valid_i   = vecs[i].vld;
            opcode_i     = vecs[i].op;
            alu_result_i = vecs[i].alu;
            store_data_i = 32'hFFFF_FFFF;
            rd_addr_i    = vecs[i].rd;
            step();
            chk($sformatf("v%0d wb_valid", i), 32'(wb_valid_o), 32'(vecs[i].e_wb));
            if (vecs[i].e_wb) begin
                chk($sformatf("v%0d wb_rd", i),   32'(wb_rd_o), 32'(vecs[i].e_rd));
                chk($sformatf("v%0d wb_data", i), wb_data_o,    vecs[i].e_data);
            end
            chk($sformatf("v%0d misalign", i), 32'(misalign_o), 32'(vecs[i].e_mis));
            chk($sformatf("v%0d req", i),      32'(dmem_req_o), 32'd0);
            chk($sformatf("v%0d ready", i),    32'(in_ready_o), 32'd1);
        end
        drive_idle();
        step();

        // LW 0x100: grant in cycle 3, stray rvalid in cycle 2, real rvalid cycle 6.
        accept(5'b00001, 32'h0000_0100, 32'h0, 5'd7);
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("lw c%0d req", c),   32'(dmem_req_o), 32'((c <= 3) ? 1 : 0));
            if (c <= 3) begin
                chk($sformatf("lw c%0d addr", c), dmem_addr_o,     32'h0000_0100);
                chk($sformatf("lw c%0d we", c),   32'(dmem_we_o),  32'd0);
            end
            chk($sformatf("lw c%0d ready", c), 32'(in_ready_o), 32'((c >= 7) ? 1 : 0));
            chk($sformatf("lw c%0d wb", c),    32'(wb_valid_o), 32'((c == 7) ? 1 : 0));
            if (c == 7) begin
                chk("lw wb_rd",   32'(wb_rd_o), 32'd7);
                chk("lw wb_data", wb_data_o,    32'hDEAD_BEEF);
            end
            dmem_gnt_i    = (c == 3);
            dmem_rvalid_i = (c == 2) || (c == 6);
            dmem_rdata_i  = (c == 6) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
            step();
        end
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;

        // SW 0x40 with immediate grant.
        accept(5'b00010, 32'h0000_0040, 32'h1234_5678, 5'd9);
        chk("sw c1 req",   32'(dmem_req_o), 32'd1);
        chk("sw c1 we",    32'(dmem_we_o),  32'd1);
        chk("sw c1 addr",  dmem_addr_o,     32'h0000_0040);
        chk("sw c1 wdata", dmem_wdata_o,    32'h1234_5678);
        chk("sw c1 ready", 32'(in_ready_o), 32'd0);
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        chk("sw c2 req",   32'(dmem_req_o), 32'd0);
        chk("sw c2 we",    32'(dmem_we_o),  32'd0);
        chk("sw c2 wdata", dmem_wdata_o,    32'd0);
        chk("sw c2 ready", 32'(in_ready_o), 32'd1);
        chk("sw c2 wb",    32'(wb_valid_o), 32'd0);
        step();
        chk("sw c3 wb",    32'(wb_valid_o), 32'd0);

        // LW timeout: grant cycle 1, WAIT from cycle 2, bus_err in cycle 6,
        // late rvalid in cycles 6-7 discarded.
        accept(5'b00001, 32'h0000_0200, 32'h0, 5'd10);
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("to c%0d bus_err", c), 32'(bus_err_o),  32'((c == 6) ? 1 : 0));
            chk($sformatf("to c%0d wb", c),      32'(wb_valid_o), 32'd0);
            chk($sformatf("to c%0d ready", c),   32'(in_ready_o), 32'((c >= 6) ? 1 : 0));
            dmem_gnt_i    = (c == 1);
            dmem_rvalid_i = (c == 6) || (c == 7);
            dmem_rdata_i  = 32'h5555_AAAA;
            step();
        end
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;

        // Asynchronous reset while in WAIT, then a normal load.
        accept(5'b00001, 32'h0000_0300, 32'h0, 5'd12);
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        step();
        chk("rw wait ready", 32'(in_ready_o), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rw rst ready", 32'(in_ready_o), 32'd1);
        chk("rw rst req",   32'(dmem_req_o), 32'd0);
        chk("rw rst wb",    32'(wb_valid_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        accept(5'b00001, 32'h0000_0304, 32'h0, 5'd13);
        chk("rw2 c1 req",  32'(dmem_req_o), 32'd1);
        chk("rw2 c1 addr", dmem_addr_o,     32'h0000_0304);
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hA5A5_0001;
        step();
        dmem_rvalid_i = 1'b0;
        chk("rw2 wb",      32'(wb_valid_o), 32'd1);
        chk("rw2 wb_rd",   32'(wb_rd_o),    32'd13);
        chk("rw2 wb_data", wb_data_o,       32'hA5A5_0001);
        chk("rw2 ready",   32'(in_ready_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
